// File: rtl/rr_stream_mux_arbiter_pkg.sv
// Shared definitions for the round-robin stream mux arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, LOCKED)
//   MAX_SEL_W   : widest grant index supported (NUM_REQ up to 8)
//   next_ptr()  : wrapping increment of a grant index for a power-of-two
//                 requester count
package mux_pkg;

  localparam int unsigned MAX_SEL_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // NUM_REQ is a power of two, so masking the incremented index by
  // num_req-1 reproduces the natural SEL_W wrap for every legal size.
  function automatic logic [MAX_SEL_W-1:0] next_ptr(
    input logic [MAX_SEL_W-1:0] gnt,
    input int unsigned          num_req
  );
    logic [MAX_SEL_W-1:0] mask;
    mask = MAX_SEL_W'(num_req - 1);
    return (gnt + 1'b1) & mask;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : highest-priority index for this pick
//   any : at least one request bit set
//   win : first set request index searching ptr, ptr+1, ... (wrapping)
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Doubling the request vector turns the wrapping search into a plain
  // shift: bit i of rot is requester (ptr+i) mod NUM_REQ.
  always_comb begin
    dbl = {req, req};
    rot = NUM_REQ'(dbl >> ptr);
    any = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        win = SEL_W'(i + 32'(ptr));
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin stream mux: shares one registered output stream among
// NUM_REQ valid/ready requesters. A grant is locked until the winner's
// last beat is accepted; arbitration costs one idle cycle per packet.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid/last : per-requester beat valid and end-of-packet flag
//   req_data       : flattened data, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_ready      : per-requester ready, at most one bit set
//   out_valid/data/last/src : registered output beat and its source index
//   out_ready      : downstream ready
module rr_stream_mux_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned DATAWIDTH = 8,
  parameter  int unsigned NUM_REQ   = 4,
  localparam int unsigned SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [DATAWIDTH-1:0]         out_data,
  output logic                         out_last,
  output logic [SEL_W-1:0]             out_src,
  input  logic                         out_ready
);

  arb_state_t           state, state_n;
  logic [SEL_W-1:0]     gnt, gnt_n;
  logic [SEL_W-1:0]     ptr, ptr_n;
  logic                 pick_any;
  logic [SEL_W-1:0]     pick_win;
  logic                 load_en;
  logic                 accept;
  logic [DATAWIDTH-1:0] req_word [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .win (pick_win)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_word[i] = req_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Output register can take a beat when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;
  assign accept  = (state == LOCKED) && req_valid[gnt] && load_en;

  always_comb begin
    req_ready = '0;
    if (state == LOCKED) begin
      req_ready[gnt] = load_en;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = LOCKED;
          gnt_n   = pick_win;
        end
      end
      LOCKED: begin
        if (accept && req_last[gnt]) begin
          state_n = IDLE;
          ptr_n   = SEL_W'(next_ptr(MAX_SEL_W'(gnt), NUM_REQ));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
    end
  end

  // A load in the same cycle as a drain overwrites the register, which
  // keeps a packet streaming at one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_word[gnt];
      out_last  <= req_last[gnt];
      out_src   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux_arbiter.sv
module tb_rr_stream_mux_arbiter;
  import mux_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;
  logic            out_ready;

  rr_stream_mux_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [1:0] s;
  } exp_t;

  exp_t       exp_q[$];
  int         obs_cyc[$];
  int         cyc;
  int         n_checks;
  int         n_fails;
  logic       abort;

  logic       v_valid [NREQ];
  logic       v_last  [NREQ];
  logic [7:0] v_data  [NREQ];
  logic [7:0] pkt_data [NREQ][4];
  int         pkt_gap  [NREQ][4];
  int         pkt_len  [NREQ];

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = v_valid[i];
      req_last[i]           = v_last[i];
      req_data[i*DW +: DW]  = v_data[i];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [7:0] d, input logic l, input logic [1:0] s);
    exp_t e;
    e.d = d; e.l = l; e.s = s;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor: pops on every output handshake and checks the
  // protocol rules each cycle.
  task automatic monitor();
    logic       hold_prev;
    logic [7:0] pd;
    logic       pl;
    logic [1:0] ps;
    exp_t       e;
    hold_prev = 1'b0;
    pd = '0; pl = 1'b0; ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (hold_prev) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(pd));
          chk("stall_last", 32'(out_last), 32'(pl));
          chk("stall_src", 32'(out_src), 32'(ps));
        end
        hold_prev = out_valid && !out_ready;
        pd = out_data; pl = out_last; ps = out_src;
        if (out_valid && out_ready) begin
          obs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(out_data), 32'(e.d));
            chk("sb_last", 32'(out_last), 32'(e.l));
            chk("sb_src", 32'(out_src), 32'(e.s));
          end
        end
      end
    end
  endtask

  // Drives one packet for requester r from the pkt_* tables; starts and
  // returns just after a rising edge.
  task automatic drive_pkt(input int r);
    bit acc;
    for (int k = 0; k < pkt_len[r]; k++) begin
      if (pkt_gap[r][k] > 0) begin
        v_valid[r] = 1'b0;
        repeat (pkt_gap[r][k]) tick();
      end
      v_valid[r] = 1'b1;
      v_data[r]  = pkt_data[r][k];
      v_last[r]  = (k == pkt_len[r] - 1);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        if (abort) begin
          v_valid[r] = 1'b0;
          return;
        end
        if (req_ready[r]) begin
          tick();
          acc = 1'b1;
        end
      end
      if (!acc) begin
        chk("driver_accept_timeout", 32'(r), 32'hFFFF_FFFF);
        v_valid[r] = 1'b0;
        return;
      end
    end
    v_valid[r] = 1'b0;
    v_last[r]  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      v_valid[i] = 1'b0; v_last[i] = 1'b0; v_data[i] = '0;
      pkt_len[i] = 0;
      for (int k = 0; k < 4; k++) begin
        pkt_gap[i][k] = 0; pkt_data[i][k] = '0;
      end
    end
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    obs_cyc.delete();
  endtask

  int c0, cr;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    abort    = 1'b0;
    fork
      monitor();
    join_none

    // Reset state and idle behaviour
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_req_ready", 32'(req_ready), 32'd0);
      chk("idle_state", 32'(dut.state), 32'(IDLE));
    end

    // Requester 2, three-beat packet
    do_reset();
    pkt_len[2] = 3;
    pkt_data[2][0] = 8'h11; pkt_data[2][1] = 8'h22; pkt_data[2][2] = 8'h33;
    push_exp(8'h11, 1'b0, 2'd2);
    push_exp(8'h22, 1'b0, 2'd2);
    push_exp(8'h33, 1'b1, 2'd2);
    c0 = cyc;
    fork
      drive_pkt(2);
    join_none
    wait_drain("t2_drain");
    chk("t2_beats", 32'(obs_cyc.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t2_beat_cycle", 32'(obs_cyc[k] - c0), 32'(k + 2));
    chk("t2_ptr", 32'(dut.ptr), 32'd3);

    // All requesters, single-beat packets, from ptr=0
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      pkt_len[r] = 1;
      pkt_data[r][0] = 8'hA0 + 8'(r);
    end
    push_exp(8'hA0, 1'b1, 2'd0);
    push_exp(8'hA1, 1'b1, 2'd1);
    push_exp(8'hA2, 1'b1, 2'd2);
    push_exp(8'hA3, 1'b1, 2'd3);
    push_exp(8'hA0, 1'b1, 2'd0);
    c0 = cyc;
    fork
      begin drive_pkt(0); drive_pkt(0); end
      drive_pkt(1);
      drive_pkt(2);
      drive_pkt(3);
    join_none
    wait_drain("t3_drain");
    chk("t3_beats", 32'(obs_cyc.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk("t3_beat_cycle", 32'(obs_cyc[k] - c0), 32'(2 + 2*k));

    // Backpressure on requester 1
    do_reset();
    pkt_len[1] = 2;
    pkt_data[1][0] = 8'h51; pkt_data[1][1] = 8'h52;
    push_exp(8'h51, 1'b0, 2'd1);
    push_exp(8'h52, 1'b1, 2'd1);
    c0 = cyc;
    fork
      drive_pkt(1);
    join_none
    repeat (2) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h51);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    cr = cyc;
    wait_drain("t4_drain");
    chk("t4_beats", 32'(obs_cyc.size()), 32'd2);
    chk("t4_second_beat_cycle", 32'(obs_cyc[1] - cr), 32'd1);

    // Grant lock while requester 0 pauses mid-packet
    do_reset();
    pkt_len[0] = 3;
    pkt_data[0][0] = 8'h01; pkt_data[0][1] = 8'h02; pkt_data[0][2] = 8'h03;
    pkt_gap[0][1] = 3;
    pkt_len[3] = 1;
    pkt_data[3][0] = 8'h3C;
    push_exp(8'h01, 1'b0, 2'd0);
    push_exp(8'h02, 1'b0, 2'd0);
    push_exp(8'h03, 1'b1, 2'd0);
    push_exp(8'h3C, 1'b1, 2'd3);
    fork
      drive_pkt(0);
      drive_pkt(3);
    join_none
    repeat (4) tick();
    chk("lock_state", 32'(dut.state), 32'(LOCKED));
    chk("lock_gnt", 32'(dut.gnt), 32'd0);
    chk("lock_req_ready", 32'(req_ready), 32'b0001);
    wait_drain("t5_drain");

    // Reset while locked with a held output beat
    do_reset();
    out_ready = 1'b0;
    pkt_len[2] = 3;
    pkt_data[2][0] = 8'h61; pkt_data[2][1] = 8'h62; pkt_data[2][2] = 8'h63;
    fork
      drive_pkt(2);
    join_none
    repeat (4) tick();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_data", 32'(out_data), 32'h61);
    chk("pre_rst_state", 32'(dut.state), 32'(LOCKED));
    abort = 1'b1;
    rst   = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ptr", 32'(dut.ptr), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst   = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    obs_cyc.delete();
    tick();
    pkt_len[1] = 1;
    pkt_data[1][0] = 8'h77;
    push_exp(8'h77, 1'b1, 2'd1);
    c0 = cyc;
    fork
      drive_pkt(1);
    join_none
    wait_drain("t6_drain");
    chk("t6_beats", 32'(obs_cyc.size()), 32'd1);
    chk("t6_beat_cycle", 32'(obs_cyc[0] - c0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux_arbiter.md
Name: rr_stream_mux_arbiter

Overview:
- Shares one DATAWIDTH-wide output stream among NUM_REQ valid/ready requesters.
- Uses round-robin arbitration with packet locking: a grant is held until the winner's last beat is accepted.
- Has a registered output stage, so each accepted beat reaches the output one cycle later.
- Sequences the shared N-to-1 data mux in front of a single downstream consumer.

Parameters:
- DATAWIDTH, 8, width of each requester data word and of out_data.
- NUM_REQ, 4, number of requesters. Must be a power of two, 2..8.
- SEL_W, $clog2(NUM_REQ), localparam. Width of the grant index and of out_src.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  in  NUM_REQ*DATAWIDTH  flattened data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_ready  out  NUM_REQ  per-requester ready; at most one bit set.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATAWIDTH  output data (registered).
- out_last  out  1  output end-of-packet flag (registered).
- out_src  out  SEL_W  index of the requester that sourced the current output beat (registered).
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - State=IDLE, gnt=0, priority pointer ptr=0.
  - req_ready=0 combinationally while in IDLE.
  - Reset mid-packet discards the packet and any held output beat. out_valid is 0 in the cycle after the reset edge.
- States: IDLE and LOCKED.
- IDLE:
  - req_ready=0 for all requesters.
  - If any req_valid bit is set: the winner w is the first set bit searching ptr, ptr+1, ... wrapping mod NUM_REQ. Next state is LOCKED with gnt=w.
  - If no bit is set: remain in IDLE.
  - Arbitration costs exactly 1 idle cycle per packet.
- LOCKED:
  - load_en = !out_valid || out_ready.
  - req_ready[gnt] = load_en; all other req_ready bits are 0.
  - A beat is accepted when req_valid[gnt] && req_ready[gnt].
  - On acceptance, next cycle: out_valid=1, out_data=req_data[gnt], out_last=req_last[gnt], out_src=gnt.
  - If the accepted beat has req_last=1: next state IDLE, ptr=(gnt+1) mod NUM_REQ with natural SEL_W wrap.
  - The grant holds even if req_valid[gnt] drops mid-packet. Other requesters wait and do not preempt.
- Output register:
  - If out_valid && out_ready and no beat is accepted in the same cycle: out_valid -> 0.
  - A simultaneous drain and load replaces the register contents, giving full throughput of 1 beat/cycle within a packet.
  - While out_valid && !out_ready: out_data, out_last and out_src are held stable and req_ready is 0.
- Throughput:
  - A packet of N beats with out_ready held at 1 occupies N+1 cycles (1 arbitration + N beats).
  - Single-beat packets from all requesters therefore achieve 50% utilisation.
- Fairness: a requester that continuously requests is granted within NUM_REQ-1 other packets.
- Assertions in the bench: onehot0(req_ready); out_* stable while out_valid && !out_ready.

Decomposition:
- Package mux_pkg holds:
  - arb_state_t enum {IDLE, LOCKED}.
  - A function next_ptr(gnt) that performs the wrapping increment.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr[SEL_W].
  - Outputs: any, win[SEL_W].
  - Implemented as a doubled-vector priority search.
  - Keeps the FSM/datapath top separable and lets the picker be tested exhaustively on its own.

Test Plan:
- Reset, then all req_valid=0 for 10 cycles -> out_valid=0, req_ready=0, state IDLE throughout.
- Requester 2 only, 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), out_ready=1 -> outputs appear on cycles 2, 3, 4 after req_valid rises, out_src=2, out_last only on 0x33; ptr becomes 3.
- All 4 requesters hold valid with single-beat packets 0xA0+i, starting from ptr=0 -> out_src sequence 0, 1, 2, 3, 0 with one gap cycle between beats.
- Backpressure: requester 1 sends a 2-beat packet while out_ready=0 for 5 cycles after the first beat -> out_data stays at beat 0, req_ready[1]=0; second beat is delivered the cycle after out_ready=1.
- Lock: requester 0 mid-packet drops valid for 3 cycles while requester 3 is valid -> no grant to 3 until requester 0's last beat is accepted; then requester 3 is granted.
- Reset asserted while LOCKED with out_valid=1 -> next cycle out_valid=0, ptr=0; a following request from requester 1 is granted normally.
